multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback with sticky traps.
// Define CU_JUMP_EN to add the JUMP state for jal/jalr; otherwise they trap as illegal.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  RegWrite,
  output logic                  ALUSrc,
  output logic                  MemToReg,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  link_sel,
  output logic                  pc_src_jalr,
  output logic [2:0]            state,
  output logic                  illegal,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
    WB = 3'd4, BRANCH = 3'd5, JUMP = 3'd6, TRAP = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR
  } kind_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA = ALU_CTRL_W'(8);

  state_t                  state_q;
  kind_t                   kind_q;
  logic [ALU_CTRL_W-1:0]   alu_q;
  logic [2:0]              f3_q;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    illegal_q;
  logic                    timeout_q;

  kind_t                   dec_kind;
  logic [ALU_CTRL_W-1:0]   dec_alu;
  logic                    dec_bad;
  logic                    unused_instr;

  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // instr[30] selects sub only for register ops; for addi it is an immediate bit
  function automatic logic [ALU_CTRL_W-1:0] alu_sel(input logic [2:0] f3, input logic b30,
                                                   input logic is_r);
    case (f3)
      3'b000:  return (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return b30 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    dec_kind = K_ALU_R;
    dec_alu  = ALU_ADD;
    dec_bad  = 1'b0;
    case (instr[6:0])
      7'b0110011: begin
        dec_kind = K_ALU_R;
        dec_alu  = alu_sel(instr[14:12], instr[30], 1'b1);
        dec_bad  = (instr[14:12] == 3'b011);
      end
      7'b0010011: begin
        dec_kind = K_ALU_I;
        dec_alu  = alu_sel(instr[14:12], instr[30], 1'b0);
        dec_bad  = (instr[14:12] == 3'b011);
      end
      7'b0000011: dec_kind = K_LOAD;
      7'b0100011: dec_kind = K_STORE;
      7'b1100011: dec_kind = K_BRANCH;
`ifdef CU_JUMP_EN
      7'b1101111: dec_kind = K_JAL;
      7'b1100111: dec_kind = K_JALR;
`endif
      default:    dec_bad = 1'b1;
    endcase
  end

  // The wait counter defaults to clear so every state change restarts it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      kind_q    <= K_ALU_R;
      alu_q     <= ALU_ADD;
      f3_q      <= 3'b000;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state_q)
        FETCH, MEM: begin
          if (mem_ready) begin
            if (state_q == FETCH)       state_q <= DECODE;
            else if (kind_q == K_LOAD)  state_q <= WB;
            else                        state_q <= FETCH;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state_q   <= TRAP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DECODE: begin
          kind_q <= dec_kind;
          alu_q  <= dec_alu;
          f3_q   <= instr[14:12];
          if (dec_bad) begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
          end else begin
            case (dec_kind)
              K_BRANCH:     state_q <= BRANCH;
              K_JAL, K_JALR: state_q <= JUMP;
              default:      state_q <= EXEC;
            endcase
          end
        end
        EXEC:     state_q <= (kind_q == K_LOAD || kind_q == K_STORE) ? MEM : WB;
        WB, JUMP: state_q <= FETCH;
        BRANCH: begin
          if (f3_q[2:1] == 2'b00) begin
            state_q <= FETCH;
          end else begin
            state_q   <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        default:  state_q <= state_q;
      endcase
    end
  end

  // Reset gates the decode so nothing (not even FETCH's mem_req) leaks while held
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    MemToReg   = 1'b0;
    ALUControl = ALU_ADD;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        EXEC: begin
          if (kind_q == K_LOAD || kind_q == K_STORE) begin
            ALUSrc     = 1'b1;
            ALUControl = ALU_ADD;
          end else begin
            ALUSrc     = (kind_q == K_ALU_I);
            ALUControl = alu_q;
          end
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = (kind_q == K_STORE);
        end
        WB: begin
          RegWrite = 1'b1;
          MemToReg = (kind_q == K_LOAD);
        end
        BRANCH: begin
          ALUControl = ALU_SUB;
          case (f3_q)
            3'b000:  pc_write = alu_zero;
            3'b001:  pc_write = ~alu_zero;
            default: pc_write = 1'b0;
          endcase
        end
`ifdef CU_JUMP_EN
        JUMP: begin
          RegWrite = 1'b1;
          pc_write = 1'b1;
          ALUSrc   = (kind_q == K_JALR);
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef CU_JUMP_EN
  assign link_sel    = !reset && (state_q == JUMP);
  assign pc_src_jalr = link_sel && (kind_q == K_JALR);
`else
  assign link_sel    = 1'b0;
  assign pc_src_jalr = 1'b0;
`endif

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

endmodule
